// File: rtl/render_pkg.sv
// Shared types and defaults for the symbol renderer.
package render_pkg;

    localparam int COORD_BITS = 16;
    localparam int COLOR_BITS = 12;
    localparam logic [COLOR_BITS-1:0] BG_COLOR = 12'h000;

    // One rectangle slot; w=0 or h=0 makes the slot invisible even if enabled.
    typedef struct packed {
        logic                  en;
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
        logic [COORD_BITS-1:0] w;
        logic [COORD_BITS-1:0] h;
        logic [COLOR_BITS-1:0] color;
    } sym_t;

endpackage

// File: rtl/sym_hit.sv
// Combinational rectangle test for one slot. The far edges are computed one
// bit wider than the coordinates so x+w past the top of the range cannot wrap
// around and produce a hit near zero.
module sym_hit
    import render_pkg::*;
(
    input  sym_t                  sym,
    input  logic [COORD_BITS-1:0] sx,
    input  logic [COORD_BITS-1:0] sy,
    output logic                  hit
);

    logic [COORD_BITS:0] x_end;
    logic [COORD_BITS:0] y_end;
    logic                in_x;
    logic                in_y;

    assign x_end = {1'b0, sym.x} + {1'b0, sym.w};
    assign y_end = {1'b0, sym.y} + {1'b0, sym.h};

    // Half-open intervals: [x, x+w) and [y, y+h); zero size is empty.
    assign in_x = (sx >= sym.x) && ({1'b0, sx} < x_end);
    assign in_y = (sy >= sym.y) && ({1'b0, sy} < y_end);
    assign hit  = sym.en && in_x && in_y;

endmodule

// File: rtl/sym_renderer.sv
// Double-buffered rectangle renderer. Writes go to a shadow table which is
// copied to the active table on frame_start; the pixel path is a fixed
// two-stage pipeline (hit detect, then priority select) with timing delayed
// to match.
module sym_renderer #(
    parameter int                NUM_SYM     = 4,
    parameter int                SYM_ID_BITS = $clog2(NUM_SYM),
    parameter int                COORD_BITS  = render_pkg::COORD_BITS,
    parameter logic [11:0]       BG_COLOR    = render_pkg::BG_COLOR
) (
    input  logic                   i_clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [SYM_ID_BITS-1:0] wr_id,
    input  logic                   wr_en,
    input  logic [COORD_BITS-1:0]  wr_x,
    input  logic [COORD_BITS-1:0]  wr_y,
    input  logic [COORD_BITS-1:0]  wr_w,
    input  logic [COORD_BITS-1:0]  wr_h,
    input  logic [11:0]            wr_color,
    input  logic                   clear_all,
    input  logic                   frame_start,
    input  logic [COORD_BITS-1:0]  sx,
    input  logic [COORD_BITS-1:0]  sy,
    input  logic                   de,
    input  logic                   n_hsync,
    input  logic                   n_vsync,
    output logic                   pending,
    output logic                   o_de,
    output logic                   o_n_hsync,
    output logic                   o_n_vsync,
    output logic [3:0]             o_r,
    output logic [3:0]             o_g,
    output logic [3:0]             o_b
);
    import render_pkg::*;

    // sym_t carries package-width geometry; COORD_BITS here must match it.

    sym_t shadow     [NUM_SYM];
    sym_t active     [NUM_SYM];
    sym_t shadow_nxt [NUM_SYM];

    logic [NUM_SYM-1:0]                 hit_c;
    logic [NUM_SYM-1:0]                 hit_s1;
    logic [NUM_SYM-1:0][COLOR_BITS-1:0] color_s1;
    logic [2:1]                         vld_pipe;   // de through the stages
    logic                               hs_s1;
    logic                               vs_s1;
    logic [COLOR_BITS-1:0]              pix_sel;

    // Next shadow contents: clear first, then a same-cycle write overrides
    // its own slot so the written slot survives clear_all.
    always_comb begin
        for (int i = 0; i < NUM_SYM; i++) begin
            shadow_nxt[i] = shadow[i];
            if (clear_all)
                shadow_nxt[i].en = 1'b0;
            if (wr_valid && (wr_id == SYM_ID_BITS'(i)))
                shadow_nxt[i] = '{en: wr_en, x: wr_x, y: wr_y, w: wr_w,
                                  h: wr_h, color: wr_color};
        end
    end

    // Shadow/active tables and pending flag; commit copies the next-shadow
    // value so an edit in the commit cycle is not lost.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SYM; i++)
                shadow[i] <= shadow_nxt[i];
            if (frame_start) begin
                for (int i = 0; i < NUM_SYM; i++)
                    active[i] <= shadow_nxt[i];
                pending <= 1'b0;
            end else if (wr_valid || clear_all) begin
                pending <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SYM; g++) begin : g_hit
        sym_hit u_hit (
            .sym (active[g]),
            .sx  (sx),
            .sy  (sy),
            .hit (hit_c[g])
        );
    end

    // Stage 1: hit vector plus a colour snapshot, so a commit landing while
    // this pixel is in flight does not change its colour.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            hit_s1      <= '0;
            color_s1    <= '0;
            vld_pipe[1] <= 1'b0;
            hs_s1       <= 1'b1;
            vs_s1       <= 1'b1;
        end else begin
            hit_s1      <= hit_c;
            for (int i = 0; i < NUM_SYM; i++)
                color_s1[i] <= active[i].color;
            vld_pipe[1] <= de;
            hs_s1       <= n_hsync;
            vs_s1       <= n_vsync;
        end
    end

    // Lowest-index hit wins; blanking forces black.
    always_comb begin
        pix_sel = BG_COLOR;
        for (int i = NUM_SYM - 1; i >= 0; i--)
            if (hit_s1[i])
                pix_sel = color_s1[i];
        if (!vld_pipe[1])
            pix_sel = '0;
    end

    // Stage 2: output registers feeding the DVI pads.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            o_n_hsync   <= 1'b1;
            o_n_vsync   <= 1'b1;
            {o_r, o_g, o_b} <= '0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            o_n_hsync   <= hs_s1;
            o_n_vsync   <= vs_s1;
            {o_r, o_g, o_b} <= pix_sel;
        end
    end

    assign o_de = vld_pipe[2];

endmodule
